led_chain_receiver: RTL and testbench
=====================================

Name: led_chain_receiver

Overview:
Receive-side model of the serial LED-driver chain. It reconstructs what one driver chip latches from the sclk/sin/xlat/mode stream produced by the pixel driver. It deserialises grayscale (GS) and dot-correction (DC) frames in the system clock domain and latches them into readable banks on XLAT. Used for loopback self-check and simulation scoreboarding; it sits beside the pixel driver on the same LED nets.

Parameters:
CHANNELS, 16, outputs per driver chip
GS_BITS, 12, grayscale bits per channel
DC_BITS, 6, dot-correction bits per channel
SYNC_STAGES, 2, synchroniser flops on each LED input

Ports:
clock  in  1  system clock; all logic on its rising edge
reset_n  in  1  asynchronous active-low reset
led_sclk  in  1  serial shift clock (asynchronous, oversampled)
led_sin  in  1  serial data, sampled on led_sclk rise
led_mode  in  1  0 = GS frame, 1 = DC frame; sampled at XLAT
led_xlat  in  1  latch strobe
led_blank  in  1  blank; high forces outputs off and clears the PWM counter
led_gsclk  in  1  grayscale PWM clock
rd_addr  in  clog2(CHANNELS)  channel select for readback
rd_gs  out  GS_BITS  GS bank value of rd_addr, registered
rd_dc  out  DC_BITS  DC bank value of rd_addr, registered
frame_pulse  out  1  one-cycle pulse on a good latch
frame_error  out  1  one-cycle pulse on a bad-length latch
frame_mode  out  1  mode of the last latch attempt
bit_count  out  clog2(CHANNELS*GS_BITS)+1  bits shifted since the last XLAT, saturating
pwm_out  out  CHANNELS  per-channel output state (only with PWM_OUT_EN)

Behaviour:
- Clock/reset: reset_n is asserted asynchronously and released synchronously through a 2-flop release. Reset clears every register, both banks, and all outputs to 0.
- Input sync: every LED input passes through SYNC_STAGES flops; rising edges are detected on the synchronised copy.
- Input timing: led_sclk and led_gsclk high and low phases are each at least SYNC_STAGES+1 clocks.
- Shift: on a sclk rise, shift left by one and insert sin at bit 0; bit_count increments and saturates at its all-ones value.
- Bit order: the first bit received is the MSB of channel CHANNELS-1.
  - GS: after CHANNELS*GS_BITS bits, channel i = sr[(i+1)*GS_BITS-1 : i*GS_BITS].
  - DC: uses the low CHANNELS*DC_BITS bits with the same layout.
- XLAT rise, mode 0:
  - bit_count == CHANNELS*GS_BITS: copy into the GS bank, pulse frame_pulse.
  - Any other count: pulse frame_error, GS bank unchanged.
- XLAT rise, mode 1: the same rule against CHANNELS*DC_BITS, writing the DC bank.
- frame_mode updates on every XLAT rise. bit_count clears to 0 on every XLAT rise, good or bad.
- Simultaneous sclk rise and xlat rise in one cycle: the shift is applied first. That bit counts toward the length check and is included in the latched data.
- Overrun (more than the expected bits): bit_count saturates; the next XLAT raises frame_error.
- Mode changing mid-stream has no effect; only the value sampled at the XLAT rise matters.
- Readback: rd_gs/rd_dc are valid 1 clock after rd_addr. rd_addr >= CHANNELS returns 0. A read in the same cycle as a latch returns the pre-latch value.
- Latency from a pin edge to its effect is SYNC_STAGES+1 clocks.

Optional Feature:
- Macro: LED_RX_PWM_OUT_EN.
- With the macro defined:
  - pwm_out exists.
  - A GS_BITS counter increments on each synchronised gsclk rise while blank is low, and saturates at all-ones.
  - blank high clears the counter to 0 and forces pwm_out to 0.
  - pwm_out[i] = !blank && (counter < gs_bank[i]), registered. A value of 0 is always off.
- Without the macro: no pwm_out port, no counter, and gsclk and blank are unused.

Decomposition:
- Package led_rx_pkg holds:
  - Defaults for CHANNELS, GS_BITS, DC_BITS.
  - GS_FRAME_BITS and DC_FRAME_BITS.
  - The mode encodings GS_MODE=0 and DC_MODE=1.
- One sub-module, led_rx_edge_sync: a SYNC_STAGES synchroniser plus rise detector, instantiated once per LED input.

Test Plan:
- Shift 192 bits (ch15=0xFFF, ch0=0x001, the rest 0x000), mode=0, XLAT -> frame_pulse once; rd_addr=15 gives rd_gs=0xFFF; rd_addr=0 gives 0x001; bit_count back to 0.
- Shift 191 bits then XLAT -> frame_error once; GS bank keeps its previous values; frame_pulse stays 0.
- Shift 96 bits (ch3=0x2A), mode=1, XLAT -> rd_dc[3]=0x2A; GS bank unchanged; frame_mode=1.
- Last sclk rise and XLAT rise on the same clock edge after 191 prior bits -> accepted as 192 bits, frame_pulse.
- Assert reset_n mid-frame after 100 bits -> all outputs 0 immediately; after release, bit_count=0 and both banks read 0.
- With LED_RX_PWM_OUT_EN and ch2=5: blank low, 8 gsclk pulses -> pwm_out[2] is high for the first 5 counts then low; blank high -> all pwm_out are 0.

Source files
------------

// File: rtl/led_rx_pkg.sv
// Shared constants for the LED chain receiver.
// Frame sizes, mode encodings and the bit counter width helper.
package led_rx_pkg;

  localparam int DEF_CHANNELS = 16;
  localparam int DEF_GS_BITS  = 12;
  localparam int DEF_DC_BITS  = 6;

  localparam int GS_FRAME_BITS = DEF_CHANNELS * DEF_GS_BITS;
  localparam int DC_FRAME_BITS = DEF_CHANNELS * DEF_DC_BITS;

  typedef enum logic {
    GS_MODE = 1'b0,
    DC_MODE = 1'b1
  } led_mode_e;

  function automatic int cnt_width(int ch, int gs);
    return $clog2(ch * gs) + 1;
  endfunction

endpackage

// File: rtl/led_rx_edge_sync.sv
// Multi-flop synchroniser with rising-edge detect on the synced level.
// STAGES must be at least 2.
module led_rx_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~prev;

endmodule

// File: rtl/led_chain_receiver.sv
// Receive-side model of one LED driver chip: GS/DC deserialise + latch.
// Optional PWM output model enabled with LED_RX_PWM_OUT_EN.
module led_chain_receiver
  import led_rx_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int GS_BITS     = DEF_GS_BITS,
  parameter int DC_BITS     = DEF_DC_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic led_sclk,
  input  logic led_sin,
  input  logic led_mode,
  input  logic led_xlat,
  input  logic led_blank,
  input  logic led_gsclk,
  input  logic [$clog2(CHANNELS)-1:0] rd_addr,
  output logic [GS_BITS-1:0] rd_gs,
  output logic [DC_BITS-1:0] rd_dc,
  output logic frame_pulse,
  output logic frame_error,
  output logic frame_mode,
`ifdef LED_RX_PWM_OUT_EN
  output logic [cnt_width(CHANNELS, GS_BITS)-1:0] bit_count,
  output logic [CHANNELS-1:0] pwm_out
`else
  output logic [cnt_width(CHANNELS, GS_BITS)-1:0] bit_count
`endif
);

  localparam int AW     = $clog2(CHANNELS);
  localparam int CW     = cnt_width(CHANNELS, GS_BITS);
  localparam int GS_LEN = CHANNELS * GS_BITS;
  localparam int DC_LEN = CHANNELS * DC_BITS;

  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n = rst_pipe[1];

  logic sclk_s, sclk_rise;
  logic sin_s, sin_rise;
  logic mode_s, mode_rise;
  logic xlat_s, xlat_rise;

  led_rx_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk (
    .clock(clock), .rst_n(rst_n), .d(led_sclk),
    .q(sclk_s), .rise(sclk_rise)
  );

  led_rx_edge_sync #(.STAGES(SYNC_STAGES)) u_sin (
    .clock(clock), .rst_n(rst_n), .d(led_sin),
    .q(sin_s), .rise(sin_rise)
  );

  led_rx_edge_sync #(.STAGES(SYNC_STAGES)) u_mode (
    .clock(clock), .rst_n(rst_n), .d(led_mode),
    .q(mode_s), .rise(mode_rise)
  );

  led_rx_edge_sync #(.STAGES(SYNC_STAGES)) u_xlat (
    .clock(clock), .rst_n(rst_n), .d(led_xlat),
    .q(xlat_s), .rise(xlat_rise)
  );

  logic [GS_LEN-1:0] sr, sr_nx;
  logic [CW-1:0]     cnt_nx;
  logic [GS_LEN-1:0] gs_bank;
  logic [DC_LEN-1:0] dc_bank;

  // Shift is resolved first so a same-cycle sclk bit joins the latch.
  always_comb begin
    sr_nx  = sr;
    cnt_nx = bit_count;
    if (sclk_rise) begin
      sr_nx = {sr[GS_LEN-2:0], sin_s};
      if (!(&bit_count)) cnt_nx = bit_count + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sr          <= '0;
      bit_count   <= '0;
      gs_bank     <= '0;
      dc_bank     <= '0;
      frame_pulse <= 1'b0;
      frame_error <= 1'b0;
      frame_mode  <= 1'b0;
    end else begin
      sr          <= sr_nx;
      bit_count   <= cnt_nx;
      frame_pulse <= 1'b0;
      frame_error <= 1'b0;
      if (xlat_rise) begin
        bit_count  <= '0;
        frame_mode <= mode_s;
        if (mode_s == DC_MODE) begin
          if (cnt_nx == CW'(DC_LEN)) begin
            dc_bank     <= sr_nx[DC_LEN-1:0];
            frame_pulse <= 1'b1;
          end else begin
            frame_error <= 1'b1;
          end
        end else begin
          if (cnt_nx == CW'(GS_LEN)) begin
            gs_bank     <= sr_nx;
            frame_pulse <= 1'b1;
          end else begin
            frame_error <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_gs <= '0;
      rd_dc <= '0;
    end else if ({1'b0, rd_addr} < (AW+1)'(CHANNELS)) begin
      rd_gs <= gs_bank[rd_addr*GS_BITS +: GS_BITS];
      rd_dc <= dc_bank[rd_addr*DC_BITS +: DC_BITS];
    end else begin
      rd_gs <= '0;
      rd_dc <= '0;
    end
  end

`ifdef LED_RX_PWM_OUT_EN
  logic gsclk_s, gsclk_rise;
  logic blank_s, blank_rise;
  logic [GS_BITS-1:0] pwm_cnt;

  led_rx_edge_sync #(.STAGES(SYNC_STAGES)) u_gsclk (
    .clock(clock), .rst_n(rst_n), .d(led_gsclk),
    .q(gsclk_s), .rise(gsclk_rise)
  );

  led_rx_edge_sync #(.STAGES(SYNC_STAGES)) u_blank (
    .clock(clock), .rst_n(rst_n), .d(led_blank),
    .q(blank_s), .rise(blank_rise)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      pwm_out <= '0;
    end else if (blank_s) begin
      pwm_cnt <= '0;
      pwm_out <= '0;
    end else begin
      if (gsclk_rise && !(&pwm_cnt)) pwm_cnt <= pwm_cnt + 1'b1;
      for (int i = 0; i < CHANNELS; i++)
        pwm_out[i] <= pwm_cnt < gs_bank[i*GS_BITS +: GS_BITS];
    end
  end

  logic unused_sig;
  assign unused_sig = ^{sclk_s, sin_rise, mode_rise, xlat_s,
                        gsclk_s, blank_rise};
`else
  logic unused_sig;
  assign unused_sig = ^{sclk_s, sin_rise, mode_rise, xlat_s,
                        led_gsclk, led_blank};
`endif

endmodule

// File: tb/tb_led_chain_receiver.sv
// Directed bench for led_chain_receiver (define LED_RX_PWM_OUT_EN for PWM).
// Readback vectors are table driven; corner cases are hand sequences.
module tb_led_chain_receiver;
  import led_rx_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic led_sclk = 1'b0, led_sin = 1'b0, led_mode = 1'b0;
  logic led_xlat = 1'b0, led_blank = 1'b0, led_gsclk = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [11:0] rd_gs;
  logic [5:0]  rd_dc;
  logic frame_pulse, frame_error, frame_mode;
  logic [8:0]  bit_count;
`ifdef LED_RX_PWM_OUT_EN
  logic [15:0] pwm_out;
`endif

  always #5 clock = ~clock;

  led_chain_receiver dut (
    .clock(clock), .reset_n(reset_n),
    .led_sclk(led_sclk), .led_sin(led_sin),
    .led_mode(led_mode), .led_xlat(led_xlat),
    .led_blank(led_blank), .led_gsclk(led_gsclk),
    .rd_addr(rd_addr), .rd_gs(rd_gs), .rd_dc(rd_dc),
    .frame_pulse(frame_pulse), .frame_error(frame_error),
    .frame_mode(frame_mode),
`ifdef LED_RX_PWM_OUT_EN
    .bit_count(bit_count), .pwm_out(pwm_out)
`else
    .bit_count(bit_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_pulse = 0;
  int n_err = 0;

  always @(negedge clock) begin
    if (frame_pulse) n_pulse++;
    if (frame_error) n_err++;
  end

  typedef struct {
    int          phase;
    logic [3:0]  addr;
    logic [11:0] gs;
    logic [5:0]  dc;
  } rb_t;

  localparam int NTBL = 13;
  rb_t tbl [NTBL];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic shift_bit(input logic b);
    @(negedge clock);
    led_sin = b;
    clks(3);
    led_sclk = 1'b1;
    clks(3);
    led_sclk = 1'b0;
  endtask

  task automatic shift_bits(input logic [191:0] f, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(f[i]);
    clks(2);
  endtask

  task automatic xlat(input logic m);
    @(negedge clock);
    led_mode = m;
    clks(3);
    led_xlat = 1'b1;
    clks(3);
    led_xlat = 1'b0;
    clks(3);
  endtask

  task automatic readback(input int ph);
    for (int i = 0; i < NTBL; i++) begin
      if (tbl[i].phase == ph) begin
        @(negedge clock);
        rd_addr = tbl[i].addr;
        @(negedge clock);
        chk($sformatf("rd_gs p%0d ch%0d", ph, tbl[i].addr),
            32'(rd_gs), 32'(tbl[i].gs));
        chk($sformatf("rd_dc p%0d ch%0d", ph, tbl[i].addr),
            32'(rd_dc), 32'(tbl[i].dc));
      end
    end
  endtask

  logic [191:0] fa, fb, fd, ones;
  int p0, e0;

  initial begin
    tbl[0]  = '{1, 4'd15, 12'hFFF, 6'h00};
    tbl[1]  = '{1, 4'd0,  12'h001, 6'h00};
    tbl[2]  = '{1, 4'd7,  12'h000, 6'h00};
    tbl[3]  = '{2, 4'd3,  12'h000, 6'h2A};
    tbl[4]  = '{2, 4'd15, 12'hFFF, 6'h00};
    tbl[5]  = '{2, 4'd0,  12'h001, 6'h00};
    tbl[6]  = '{3, 4'd5,  12'hABC, 6'h00};
    tbl[7]  = '{3, 4'd15, 12'h123, 6'h00};
    tbl[8]  = '{3, 4'd0,  12'h000, 6'h00};
    tbl[9]  = '{3, 4'd3,  12'h000, 6'h2A};
    tbl[10] = '{4, 4'd15, 12'h000, 6'h00};
    tbl[11] = '{4, 4'd3,  12'h000, 6'h00};
    tbl[12] = '{4, 4'd5,  12'h000, 6'h00};

    fa = '0; fa[191:180] = 12'hFFF; fa[11:0] = 12'h001;
    fb = '0; fb[191:180] = 12'h123; fb[71:60] = 12'hABC;
    fd = '0; fd[23:18] = 6'h2A;
    ones = '1;

    clks(3);
    reset_n = 1'b1;
    clks(5);
    chk("reset rd_gs", 32'(rd_gs), 0);
    chk("reset rd_dc", 32'(rd_dc), 0);
    chk("reset frame_pulse", 32'(frame_pulse), 0);
    chk("reset frame_error", 32'(frame_error), 0);
    chk("reset frame_mode", 32'(frame_mode), 0);
    chk("reset bit_count", 32'(bit_count), 0);

    shift_bits(fa, GS_FRAME_BITS);
    chk("count gs frame", 32'(bit_count), 192);
    p0 = n_pulse; e0 = n_err;
    xlat(1'b0);
    chk("gs pulse", 32'(n_pulse - p0), 1);
    chk("gs no error", 32'(n_err - e0), 0);
    chk("gs count clear", 32'(bit_count), 0);
    chk("gs mode", 32'(frame_mode), 0);
    readback(1);

    shift_bits(ones, GS_FRAME_BITS - 1);
    chk("count short", 32'(bit_count), 191);
    p0 = n_pulse; e0 = n_err;
    xlat(1'b0);
    chk("short error", 32'(n_err - e0), 1);
    chk("short no pulse", 32'(n_pulse - p0), 0);
    chk("short count clear", 32'(bit_count), 0);
    readback(1);

    shift_bits(fd, DC_FRAME_BITS);
    p0 = n_pulse; e0 = n_err;
    xlat(1'b1);
    chk("dc pulse", 32'(n_pulse - p0), 1);
    chk("dc no error", 32'(n_err - e0), 0);
    chk("dc mode", 32'(frame_mode), 1);
    readback(2);

    for (int i = 0; i < 515; i++) shift_bit(1'b1);
    clks(2);
    chk("overrun saturate", 32'(bit_count), 511);
    p0 = n_pulse; e0 = n_err;
    xlat(1'b0);
    chk("overrun error", 32'(n_err - e0), 1);
    chk("overrun no pulse", 32'(n_pulse - p0), 0);
    chk("overrun mode", 32'(frame_mode), 0);

    @(negedge clock);
    led_mode = 1'b1;
    shift_bits(fb >> 1, GS_FRAME_BITS - 1);
    @(negedge clock);
    led_sin = fb[0];
    led_mode = 1'b0;
    clks(3);
    led_sclk = 1'b1;
    led_xlat = 1'b1;
    clks(3);
    led_sclk = 1'b0;
    led_xlat = 1'b0;
    p0 = n_pulse - ((frame_pulse === 1'b1) ? 1 : 0);
    clks(4);
    chk("same-edge count clear", 32'(bit_count), 0);
    chk("same-edge mode", 32'(frame_mode), 0);
    readback(3);

    @(negedge clock);
    rd_addr = 4'd15;
    clks(2);
    chk("pre-reset rd_gs", 32'(rd_gs), 32'h123);
    for (int i = 0; i < 100; i++) shift_bit(1'b1);
    clks(2);
    chk("mid-frame count", 32'(bit_count), 100);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("async rst rd_gs", 32'(rd_gs), 0);
    chk("async rst bit_count", 32'(bit_count), 0);
    chk("async rst pulse", 32'(frame_pulse), 0);
    chk("async rst error", 32'(frame_error), 0);
    clks(3);
    reset_n = 1'b1;
    clks(5);
    chk("post-rst bit_count", 32'(bit_count), 0);
    readback(4);

`ifdef LED_RX_PWM_OUT_EN
    fa = '0; fa[35:24] = 12'h005;
    shift_bits(fa, GS_FRAME_BITS);
    xlat(1'b0);
    clks(2);
    for (int k = 0; k <= 8; k++) begin
      chk($sformatf("pwm count %0d", k), 32'(pwm_out),
          (k < 5) ? 32'h0004 : 32'h0000);
      if (k < 8) begin
        @(negedge clock);
        led_gsclk = 1'b1;
        clks(3);
        led_gsclk = 1'b0;
        clks(3);
      end
    end
    @(negedge clock);
    led_blank = 1'b1;
    clks(5);
    chk("pwm blank", 32'(pwm_out), 0);
    led_blank = 1'b0;
    clks(5);
    chk("pwm unblank", 32'(pwm_out), 32'h0004);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  int p_same;
  initial begin
    p_same = 0;
  end

  always @(negedge clock) begin
    if (frame_pulse && led_xlat && led_sclk) p_same++;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
